// File: rtl/display_scan_controller.sv
// Scans a frame of 4-bit digit codes across DIGITS positions through one
// shared 7-segment decoder. Each slot blanks all digits first and then lights
// one digit. New frames wait in a single shadow register and are only swapped
// in at a frame boundary, so a frame is never shown half old and half new.
module display_scan_controller #(
   parameter int DIGITS       = 6,
   parameter int SCAN_DIV     = 1000,
   parameter int BLANK_CYCLES = 2
) (
   input  logic                  clock,
   input  logic                  resetN,
   input  logic [4*DIGITS-1:0]   digitsIn,
   input  logic                  loadValid,
   output logic                  loadReady,
   input  logic [DIGITS-1:0]     blankMask,
   output logic [3:0]            characterOut,
   input  logic [6:0]            segmentDataIn,
   output logic [6:0]            segmentsOut,
   output logic [DIGITS-1:0]     anodesOut,
   output logic                  frameStart
);

   localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

   // IDLE exists only between reset release and the first clock edge
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      DRIVE = 2'd2
   } scanStateT;

   scanStateT            r_state;
   logic [CNT_W-1:0]     r_cnt;
   logic [IDX_W-1:0]     r_slotIdx;
   logic                 r_maskHold;
   logic [4*DIGITS-1:0]  r_active;
   logic [4*DIGITS-1:0]  r_shadow;
   logic                 r_shadowFull;
   logic                 r_loadReady;
   logic [3:0]           r_characterOut;
   logic [6:0]           r_segmentsOut;
   logic [DIGITS-1:0]    r_anodesOut;
   logic                 r_frameStart;

   logic                 w_blankDone;
   logic                 w_driveDone;
   logic                 w_slotStart;
   logic [IDX_W-1:0]     w_nextIdx;
   logic                 w_frameBoundary;
   logic                 w_accept;
   logic                 w_swap;
   logic [3:0]           w_nextChar;

   assign w_blankDone     = (r_state == BLANK) && (r_cnt == BLANK_LAST);
   assign w_driveDone     = (r_state == DRIVE) && (r_cnt == DRIVE_LAST);
   assign w_slotStart     = (r_state == IDLE) || w_driveDone;
   assign w_nextIdx       = ((r_state == IDLE) || (r_slotIdx == IDX_LAST)) ?
                            '0 : r_slotIdx + IDX_W'(1);
   assign w_frameBoundary = w_slotStart && (w_nextIdx == '0);
   assign w_accept        = loadValid && r_loadReady;
   assign w_swap          = w_frameBoundary && r_shadowFull;
   assign w_nextChar      = w_swap ? r_shadow[{w_nextIdx, 2'b00} +: 4]
                                   : r_active[{w_nextIdx, 2'b00} +: 4];

   assign loadReady    = r_loadReady;
   assign characterOut = r_characterOut;
   assign segmentsOut  = r_segmentsOut;
   assign anodesOut    = r_anodesOut;
   assign frameStart   = r_frameStart;

   // Shadow register handshake; ready stays low through the swap cycle and returns one cycle later
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_shadow     <= '0;
         r_shadowFull <= 1'b0;
         r_loadReady  <= 1'b1;
      end else if (w_accept) begin
         r_shadow     <= digitsIn;
         r_shadowFull <= 1'b1;
         r_loadReady  <= 1'b0;
      end else begin
         if (w_swap) begin
            r_shadowFull <= 1'b0;
         end
         r_loadReady <= !r_shadowFull;
      end
   end

   // Scan state machine: blank then drive each slot, swapping the frame in at slot 0
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_state        <= IDLE;
         r_cnt          <= '0;
         r_slotIdx      <= '0;
         r_maskHold     <= 1'b0;
         r_active       <= '0;
         r_characterOut <= 4'h0;
         r_segmentsOut  <= 7'h00;
         r_anodesOut    <= '0;
         r_frameStart   <= 1'b0;
      end else begin
         r_frameStart <= w_frameBoundary;
         if (w_slotStart) begin
            r_state        <= BLANK;
            r_cnt          <= '0;
            r_slotIdx      <= w_nextIdx;
            r_maskHold     <= blankMask[w_nextIdx];
            r_characterOut <= w_nextChar;
            r_segmentsOut  <= 7'h00;
            r_anodesOut    <= '0;
            if (w_swap) begin
               r_active <= r_shadow;
            end
         end else begin
            case (r_state)
               BLANK: begin
                  if (w_blankDone) begin
                     r_state <= DRIVE;
                     r_cnt   <= '0;
                     if (!r_maskHold) begin
                        r_anodesOut   <= DIGITS'(1) << r_slotIdx;
                        r_segmentsOut <= segmentDataIn;
                     end
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
               DRIVE: begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
               default: begin
                  r_state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_display_scan_controller.sv
// Testbench for display_scan_controller: a reference model predicts every
// output cycle from slot/frame arithmetic and queues it; a monitor pops and
// compares each cycle while the stimulus thread loads frames and masks.
module tb_display_scan_controller;

   localparam int DIGITS       = 6;
   localparam int SCAN_DIV     = 4;
   localparam int BLANK_CYCLES = 2;
   localparam int SLOT         = BLANK_CYCLES + SCAN_DIV;
   localparam int FRAME        = DIGITS * SLOT;

   logic                 clock = 1'b0;
   logic                 resetN;
   logic [4*DIGITS-1:0]  digitsIn;
   logic                 loadValid;
   logic                 loadReady;
   logic [DIGITS-1:0]    blankMask;
   logic [3:0]           characterOut;
   logic [6:0]           segmentDataIn;
   logic [6:0]           segmentsOut;
   logic [DIGITS-1:0]    anodesOut;
   logic                 frameStart;

   typedef struct packed {
      logic              fs;
      logic              rdy;
      logic [3:0]        ch;
      logic [DIGITS-1:0] an;
      logic [6:0]        seg;
   } expT;

   expT  expQ[$];
   int   checkCount = 0;
   int   passCount  = 0;

   int          mN         = -1;
   logic [3:0]  mActive [DIGITS];
   logic [23:0] mPend      = '0;
   bit          mPendValid = 1'b0;
   bit          mReady     = 1'b1;
   bit          mMask      = 1'b0;
   bit          mStarted   = 1'b0;

   display_scan_controller #(
      .DIGITS(DIGITS),
      .SCAN_DIV(SCAN_DIV),
      .BLANK_CYCLES(BLANK_CYCLES)
   ) dut (
      .clock(clock),
      .resetN(resetN),
      .digitsIn(digitsIn),
      .loadValid(loadValid),
      .loadReady(loadReady),
      .blankMask(blankMask),
      .characterOut(characterOut),
      .segmentDataIn(segmentDataIn),
      .segmentsOut(segmentsOut),
      .anodesOut(anodesOut),
      .frameStart(frameStart)
   );

   // Free-running system clock
   always #5 clock = ~clock;

   // Standard hex 7-segment patterns, segment A at bit 0
   function automatic logic [6:0] segOf(input logic [3:0] c);
      case (c)
         4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
         4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
         4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
         4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
      endcase
   endfunction

   // Model decoder attached to the shared character bus
   always_comb segmentDataIn = segOf(characterOut);

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   task automatic reportBoundFail(input string name);
      checkCount++;
      $display("[TB] FAIL %s: wait bound expired, got timeout, expected event", name);
   endtask

   // Reference model: each cycle's outputs follow from its position in the frame
   always @(posedge clock or negedge resetN) begin
      int  pos, slot, inSlot;
      bit  accept, swapped, lit;
      expT e;
      if (!resetN) begin
         mN         = -1;
         mPend      = '0;
         mPendValid = 1'b0;
         mReady     = 1'b1;
         mMask      = 1'b0;
         mStarted   = 1'b0;
         foreach (mActive[k]) mActive[k] = 4'h0;
         expQ.delete();
      end else begin
         accept  = loadValid && mReady;
         mN++;
         pos     = mN % FRAME;
         slot    = pos / SLOT;
         inSlot  = pos % SLOT;
         swapped = 1'b0;
         if (pos == 0 && mPendValid) begin
            foreach (mActive[k]) mActive[k] = mPend[4*k +: 4];
            mPendValid = 1'b0;
            swapped    = 1'b1;
         end
         if (accept) begin
            mPend      = digitsIn;
            mPendValid = 1'b1;
         end
         mReady = !(mPendValid || swapped);
         if (inSlot == 0) mMask = blankMask[slot];
         lit    = (inSlot >= BLANK_CYCLES) && !mMask;
         e.fs   = (pos == 0);
         e.rdy  = mReady;
         e.ch   = mActive[slot];
         e.an   = lit ? (6'd1 << slot) : 6'd0;
         e.seg  = lit ? segOf(mActive[slot]) : 7'h00;
         expQ.push_back(e);
         mStarted = 1'b1;
      end
   end

   // Monitor: pop one expected record per cycle and compare away from the active edge
   always @(negedge clock) begin
      expT e;
      if (resetN === 1'b1 && mStarted) begin
         if (expQ.size() == 0) begin
            reportBoundFail("scoreboardEmpty");
         end else begin
            e = expQ.pop_front();
            checkOutput($sformatf("frameStart@%0d", mN),   frameStart,   e.fs);
            checkOutput($sformatf("loadReady@%0d", mN),    loadReady,    e.rdy);
            checkOutput($sformatf("characterOut@%0d", mN), characterOut, e.ch);
            checkOutput($sformatf("anodesOut@%0d", mN),    anodesOut,    e.an);
            checkOutput($sformatf("segmentsOut@%0d", mN),  segmentsOut,  e.seg);
         end
      end
   end

   task automatic waitForPos(input int p);
      for (int i = 0; i < 4*FRAME; i++) begin
         if (mN >= 0 && (mN % FRAME) == p) return;
         @(negedge clock);
      end
      reportBoundFail("waitForPos");
   endtask

   task automatic waitForSlotMid();
      for (int i = 0; i < 4*SLOT; i++) begin
         if (mN >= 0 && (mN % SLOT) == 3) return;
         @(negedge clock);
      end
      reportBoundFail("waitForSlotMid");
   endtask

   // Producer side of the handshake: hold the request until it is taken
   task automatic applyStimulus(input logic [23:0] frame);
      logic sawReady;
      digitsIn  = frame;
      loadValid = 1'b1;
      for (int i = 0; i < 4*FRAME; i++) begin
         sawReady = loadReady;
         @(negedge clock);
         if (sawReady) begin
            loadValid = 1'b0;
            digitsIn  = ~frame;
            return;
         end
      end
      loadValid = 1'b0;
      reportBoundFail("loadHandshake");
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "CharacterOut"}, characterOut, 4'h0);
      checkOutput({tag, "SegmentsOut"},  segmentsOut,  7'h00);
      checkOutput({tag, "AnodesOut"},    anodesOut,    6'h00);
      checkOutput({tag, "FrameStart"},   frameStart,   1'b0);
      checkOutput({tag, "LoadReady"},    loadReady,    1'b1);
   endtask

   // Directed scenarios followed by randomized frame loads and mask changes
   initial begin
      logic [31:0] r;
      resetN    = 1'b0;
      loadValid = 1'b0;
      digitsIn  = '0;
      blankMask = '0;
      repeat (3) @(negedge clock);
      checkResetOutputs("reset");
      #1 resetN = 1'b1;

      // Idle scanning of an all-zero frame
      repeat (2*FRAME + 3) @(negedge clock);

      // Mid-frame load shows only after the next frame boundary
      waitForPos(10);
      applyStimulus(24'h123456);
      repeat (2*FRAME) @(negedge clock);

      // Back-to-back frames: the second waits for the shadow to drain
      waitForPos(5);
      applyStimulus(24'hAAAAAA);
      applyStimulus(24'hBCDEF9);
      repeat (3*FRAME) @(negedge clock);

      // Load on the frameStart cycle itself with an empty shadow
      waitForPos(0);
      applyStimulus(24'h777888);
      repeat (2*FRAME + 5) @(negedge clock);

      // Leading-zero blanking of digit 5, then a mid-slot mask change
      applyStimulus(24'h0ABCDE);
      repeat (FRAME + 2) @(negedge clock);
      waitForSlotMid();
      blankMask = 6'b100000;
      repeat (2*FRAME) @(negedge clock);
      waitForPos(2*SLOT + 3);
      blankMask = 6'b000100;
      repeat (FRAME) @(negedge clock);
      waitForSlotMid();
      blankMask = '0;

      // Asynchronous reset while digit 3 is lit with a frame pending
      applyStimulus(24'h987654);
      repeat (2*FRAME) @(negedge clock);
      applyStimulus(24'h111111);
      waitForPos(3*SLOT + 3);
      #1 resetN = 1'b0;
      #1 checkResetOutputs("asyncReset");
      repeat (3) @(negedge clock);
      #1 resetN = 1'b1;
      #1 checkOutput("releaseLoadReady", loadReady, 1'b1);
      repeat (2*FRAME) @(negedge clock);

      // Randomized loads, including hex codes 10..15, with occasional mask changes
      for (int it = 0; it < 10; it++) begin
         repeat ($urandom_range(0, 40)) @(negedge clock);
         if ($urandom_range(0, 1) == 1) begin
            waitForSlotMid();
            r = $urandom;
            blankMask = r[DIGITS-1:0];
         end
         r = $urandom;
         applyStimulus(r[23:0]);
      end
      repeat (3*FRAME) @(negedge clock);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
Time-multiplexes one shared 4-bit-to-7-segment decoder across DIGITS common-anode/common-cathode digit positions of the 24-hour clock display (HH MM SS). Accepts a new digit frame from the timekeeping logic over a valid/ready handshake, holds it in a shadow register and swaps it in only at a frame boundary, so the display never tears. It drives the decoder's character input, registers the decoder's segment result, and generates one-hot digit enables with inter-digit blanking to suppress ghosting.

Parameters:
DIGITS, 6, number of multiplexed digit positions; index 0 is scanned first.
SCAN_DIV, 1000, clock cycles each digit is driven (lit); legal range is at least 1.
BLANK_CYCLES, 2, clock cycles of all-off before each digit is driven; legal range is at least 1.

Ports:
clock  in  1  system clock; all state updates on rising edge.
resetN  in  1  asynchronous, active-low reset.
digitsIn  in  4*DIGITS  digit codes for a new frame; digit k is bits [4k+3:4k].
loadValid  in  1  digitsIn is valid this cycle.
loadReady  out  1  the shadow register is empty and can accept a frame.
blankMask  in  DIGITS  bit k=1 forces digit k dark (leading-zero suppression, flashing while setting time).
characterOut  out  4  code for the digit being scanned; drives the shared decoder's character input.
segmentDataIn  in  7  decoder result (A at bit 0 .. G at bit 6), combinational from characterOut.
segmentsOut  out  7  registered segment drive, active-high.
anodesOut  out  DIGITS  registered one-hot digit enable, active-high.
frameStart  out  1  one-cycle pulse on the first cycle of slot 0.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values: characterOut=0, segmentsOut=0, anodesOut=0, loadReady=1, frameStart=0. The active frame, shadow frame, digit index, cycle counter and state are all cleared. Reset asserted mid-frame aborts the frame immediately; pending data is discarded.
- Slot k spans BLANK_CYCLES+SCAN_DIV cycles. A frame spans DIGITS slots. The index wraps from DIGITS-1 to 0 with no gap.
- State machine:
  - BLANK: counter runs 0..BLANK_CYCLES-1, then goes to DRIVE.
  - DRIVE: counter runs 0..SCAN_DIV-1, then goes to BLANK of the next slot.
  - After reset release, the first clock edge begins BLANK of slot 0, and frameStart=1 in that cycle.
- Let t0 be the first BLANK cycle of slot k:
  - From t0 onward, characterOut = active[k].
  - blankMask[k] is sampled at t0 and held for the whole slot.
  - Cycles t0 .. t0+BLANK_CYCLES-1: anodesOut=0 and segmentsOut=0.
  - Cycles t0+BLANK_CYCLES .. t0+BLANK_CYCLES+SCAN_DIV-1:
    - If the sampled mask bit is 0: anodesOut = 1<<k and segmentsOut = segmentDataIn as captured from the decoder, which has had at least one cycle to settle.
    - If the sampled mask bit is 1: anodesOut=0 and segmentsOut=0.
- At no cycle are two anode bits high. No anode is high in the cycle characterOut changes.
- Handshake:
  - A frame is accepted on a rising edge where loadValid=1 and loadReady=1. digitsIn is written to the shadow register and loadReady falls on the next cycle.
  - loadValid with loadReady=0 has no effect; the producer must hold its request.
- Frame swap: at t0 of slot 0, if the shadow register was full before that edge, the shadow register is copied to the active frame, the shadow is marked empty, and loadReady=1 from the following cycle. characterOut in that same t0 cycle already shows the new digit 0.
- Simultaneous events:
  - A handshake in the same cycle as a swap edge can only occur when the shadow was empty, so no swap happens at that boundary. The new frame is held and applied at the next frame boundary.
  - Several frames cannot queue; a single shadow entry is the limit.
- Digit codes 10..15 pass through unmodified; the decoder renders them as hex.

Test Plan:
(Parameters for all cases: DIGITS=6, SCAN_DIV=4, BLANK_CYCLES=2, so slot=6 cycles and frame=36 cycles.)
1. Release reset with no load -> frameStart pulses every 36 cycles. characterOut=0 throughout. anodesOut goes 0,0,1,1,1,1 then 0,0,2,2,2,2 ... 0,0,0x20 x4. With a model decoder, segmentsOut=0x3F while lit and 0 while blank.
2. Load digitsIn=0x123456 (digit0=6 .. digit5=1) mid-frame -> loadReady drops the next cycle. Digits stay 0 until the next frameStart. Then characterOut sequence is 6,5,4,3,2,1 and loadReady=1 one cycle after that frameStart.
3. Load frame A, then hold loadValid with frame B before the boundary -> B is not accepted until loadReady returns. A displays for one full frame and B from the following frame.
4. Load exactly on the frameStart cycle with the shadow empty -> the frame is not shown in that frame; it is shown from the next frameStart 36 cycles later.
5. blankMask=0b100000 with digit5=0 -> anodesOut bit 5 is never high and segmentsOut=0 during slot 5. Other digits are unaffected. Toggling the mask mid-slot takes effect at the next slot boundary.
6. Assert resetN=0 during DRIVE of slot 3 with a frame pending -> outputs are zero immediately, without waiting for a clock edge. After release, scanning restarts at slot 0 with all digits 0, and the pending frame is gone (loadReady=1).
